// File: rtl/sdram_line_prefetch_if.sv
// sdram_line_prefetch_if: request, slot read/release and SDRAM command signals of the line prefetcher
// slave  : prefetcher view (drives SDRAM commands, req_ready/req_err, slot_valid, rd_data, fill_slot)
// master : environment view (SDRAM controller responses, line requests, read port, releases)
interface sdram_line_prefetch_if #(
  parameter int ADDR_W = 23,
  parameter int LINES = 2,
  parameter int BYTES_PER_PX = 2
);
  localparam int SW = $clog2(LINES);
  logic sdram_rd;
  logic sdram_refresh;
  logic [ADDR_W-1:0] sdram_addr;
  logic [7:0] sdram_dout;
  logic sdram_data_ready;
  logic sdram_busy;
  logic req_valid;
  logic req_ready;
  logic [11:0] req_line;
  logic [ADDR_W-1:0] frame_base;
  logic req_err;
  logic [LINES-1:0] slot_valid;
  logic [SW-1:0] rd_slot;
  logic [11:0] rd_x;
  logic [8*BYTES_PER_PX-1:0] rd_data;
  logic rel_valid;
  logic [SW-1:0] rel_slot;
  logic [SW-1:0] fill_slot;
  modport slave (
    output sdram_rd, sdram_refresh, sdram_addr, req_ready, req_err, slot_valid, rd_data, fill_slot,
    input sdram_dout, sdram_data_ready, sdram_busy, req_valid, req_line, frame_base, rd_slot, rd_x,
          rel_valid, rel_slot
  );
  modport master (
    input sdram_rd, sdram_refresh, sdram_addr, req_ready, req_err, slot_valid, rd_data, fill_slot,
    output sdram_dout, sdram_data_ready, sdram_busy, req_valid, req_line, frame_base, rd_slot, rd_x,
           rel_valid, rel_slot
  );
endinterface

// File: rtl/sdram_line_prefetch.sv
// sdram_line_prefetch: fetches scanlines byte-by-byte from SDRAM into a ring of line slots
// clk_sdram : the only clock
// rst       : synchronous active-high reset
// bus       : sdram_line_prefetch_if.slave (SDRAM commands, line requests, slot read/release port)
// Optional LINE_PREFETCH_REFRESH_EN: internal refresh timer drives sdram_refresh; otherwise it stays 0.
module sdram_line_prefetch #(
  parameter int IMG_W = 1280,
  parameter int IMG_H = 720,
  parameter int BYTES_PER_PX = 2,
  parameter int LINES = 2,
  parameter int ADDR_W = 23,
  parameter int REFRESH_INTERVAL = 400
) (
  input logic clk_sdram,
  input logic rst,
  sdram_line_prefetch_if.slave bus
);
  localparam int SW = $clog2(LINES);
  localparam int PW = 8 * BYTES_PER_PX;
  localparam int BW = BYTES_PER_PX > 1 ? $clog2(BYTES_PER_PX) : 1;
  localparam int MW = $clog2(LINES * IMG_W);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, NEXT} state_t;
  state_t state, state_n;
  logic [11:0] x, line_r;
  logic [BW-1:0] b;
  logic [ADDR_W-1:0] base_r, off;
  logic [PW-1:0] pix;
  logic [PW-1:0] mem [LINES*IMG_W];
  logic [SW-1:0] fill;
  logic [LINES-1:0] valid, rel_m, set_m;
  logic [MW-1:0] wa, ra;
  logic accept, bad, last_b, last_x, do_rd, do_ref, ref_pend;
  assign accept = bus.req_valid && bus.req_ready;
  assign bad = 32'(bus.req_line) >= 32'(IMG_H);
  assign last_b = 32'(b) == 32'(BYTES_PER_PX - 1);
  assign last_x = 32'(x) == 32'(IMG_W - 1);
  // offset is formed at 32 bits and truncated, so the address wraps modulo 2^ADDR_W
  assign off = ADDR_W'((32'(line_r) * 32'(IMG_W) + 32'(x)) * 32'(BYTES_PER_PX) + 32'(b));
  assign wa = MW'(32'(fill) * 32'(IMG_W) + 32'(x));
  assign ra = MW'(32'(bus.rd_slot) * 32'(IMG_W) + 32'(bus.rd_x));
  assign rel_m = bus.rel_valid ? LINES'(1) << bus.rel_slot : '0;
  assign set_m = state == NEXT && last_x ? LINES'(1) << fill : '0;
  assign bus.req_ready = state == IDLE && !valid[fill];
  assign bus.slot_valid = valid;
  assign bus.fill_slot = fill;
  always_ff @(posedge clk_sdram)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept && !bad ? ISSUE : IDLE;
      ISSUE: state_n = !bus.sdram_busy && !ref_pend ? WAIT : ISSUE;
      WAIT: state_n = !bus.sdram_data_ready ? WAIT : last_b ? STORE : ISSUE;
      STORE: state_n = NEXT;
      NEXT: state_n = last_x ? IDLE : ISSUE;
      default: state_n = IDLE;
    endcase
  end
  // refresh takes priority over reads in ISSUE; strobes are registered so they never overlap
  always_comb begin
    do_ref = ref_pend && !bus.sdram_busy && (state == IDLE || state == ISSUE);
    do_rd = state == ISSUE && !bus.sdram_busy && !ref_pend;
  end
  always_ff @(posedge clk_sdram) begin
    if (rst) begin
      x <= '0;
      b <= '0;
      line_r <= '0;
      base_r <= '0;
      pix <= '0;
      fill <= '0;
      valid <= '0;
      bus.sdram_rd <= 1'b0;
      bus.sdram_refresh <= 1'b0;
      bus.sdram_addr <= '0;
      bus.req_err <= 1'b0;
    end else begin
      bus.sdram_rd <= do_rd;
      bus.sdram_refresh <= do_ref;
      bus.req_err <= accept && bad;
      if (do_rd) bus.sdram_addr <= base_r + off;
      if (accept) begin
        line_r <= bus.req_line;
        base_r <= bus.frame_base;
        x <= '0;
        b <= '0;
      end
      if (state == WAIT && bus.sdram_data_ready) begin
        pix[8*b +: 8] <= bus.sdram_dout;
        if (!last_b) b <= b + 1'b1;
      end
      if (state == NEXT && !last_x) begin
        x <= x + 12'd1;
        b <= '0;
      end
      if (state == NEXT && last_x) fill <= fill + 1'b1;
      // set after clear: the slot being completed cannot have been valid
      valid <= (valid & ~rel_m) | set_m;
    end
  end
  always_ff @(posedge clk_sdram)
    if (state == STORE) mem[wa] <= pix;
  always_ff @(posedge clk_sdram)
    bus.rd_data <= rst ? '0 : mem[ra];
`ifdef LINE_PREFETCH_REFRESH_EN
  localparam int TW = $clog2(REFRESH_INTERVAL + 1);
  logic [TW-1:0] tmr;
  logic wrap;
  assign wrap = tmr == TW'(REFRESH_INTERVAL - 1);
  always_ff @(posedge clk_sdram) begin
    if (rst) begin
      tmr <= '0;
      ref_pend <= 1'b0;
    end else begin
      tmr <= wrap ? '0 : tmr + 1'b1;
      ref_pend <= wrap || (ref_pend && !do_ref);
    end
  end
`else
  assign ref_pend = 1'b0;
`endif
endmodule

// File: tb/tb_sdram_line_prefetch.sv
// tb_sdram_line_prefetch: scoreboard bench for sdram_line_prefetch with a zero-latency SDRAM model
module tb_sdram_line_prefetch;
  localparam int IW = 8, IH = 16, BPP = 2, LN = 4, AW = 23, RI = 10;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  sdram_line_prefetch_if #(.ADDR_W(AW), .LINES(LN), .BYTES_PER_PX(BPP)) bus ();
  sdram_line_prefetch #(
    .IMG_W(IW), .IMG_H(IH), .BYTES_PER_PX(BPP), .LINES(LN), .ADDR_W(AW), .REFRESH_INTERVAL(RI)
  ) dut (
    .clk_sdram(clk),
    .rst(rst),
    .bus(bus)
  );
  int n_cmp = 0, n_mis = 0, rd_cnt = 0, ref_cnt = 0;
  logic [AW-1:0] addr_q[$];
  logic [15:0] rd_q[$];
  logic rd_req = 0, rd_req_d = 0, stray = 0;

  function automatic logic [7:0] memb(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [15:0] pixv(input logic [AW-1:0] base, input int line, input int x);
    logic [AW-1:0] a, a1;
    a = base + AW'((line * IW + x) * BPP);
    a1 = a + 1'b1;
    return {memb(a1), memb(a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bus.sdram_data_ready = bus.sdram_rd | stray;
    bus.sdram_dout = bus.sdram_rd ? memb(bus.sdram_addr) : 8'hEE;
  end

  always @(posedge clk) rd_req_d <= rd_req;

  always @(negedge clk) begin
    if (bus.sdram_rd) begin
      rd_cnt++;
      if (addr_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_rd: got read at %0h required no read", bus.sdram_addr);
      end else chk("rd_addr", 32'(bus.sdram_addr), 32'(addr_q.pop_front()));
    end
    if (bus.sdram_refresh) begin
      ref_cnt++;
      chk("rd_ref_excl", 32'(bus.sdram_rd), 0);
    end
    if (rd_req_d) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL rd_q_empty: got %0h required a queued pixel", bus.rd_data);
      end else chk("rd_data", 32'(bus.rd_data), 32'(rd_q.pop_front()));
    end
  end

  task automatic start_req(input int line, input logic [AW-1:0] base);
    int t;
    t = 0;
    while (!bus.req_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_before_req", 32'(bus.req_ready), 1);
    bus.req_valid = 1;
    bus.req_line = 12'(line);
    bus.frame_base = base;
    if (line < IH)
      for (int x = 0; x < IW; x++)
        for (int b = 0; b < BPP; b++) addr_q.push_back(base + AW'((line * IW + x) * BPP + b));
    @(negedge clk);
    bus.req_valid = 0;
  endtask

  task automatic wait_slot(input int s);
    int t;
    t = 0;
    while (!bus.slot_valid[s] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("line_done_s%0d", s), 32'(bus.slot_valid[s]), 1);
  endtask

  task automatic rd(input int s, input int x, input logic [15:0] exp);
    bus.rd_slot = 2'(s);
    bus.rd_x = 12'(x);
    rd_q.push_back(exp);
    rd_req = 1;
    @(negedge clk);
    rd_req = 0;
  endtask

  task automatic release_slot(input int s);
    bus.rel_valid = 1;
    bus.rel_slot = 2'(s);
    @(negedge clk);
    bus.rel_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int t, start;
    bus.sdram_busy = 0;
    bus.req_valid = 0;
    bus.req_line = 0;
    bus.frame_base = 0;
    bus.rd_slot = 0;
    bus.rd_x = 0;
    bus.rel_valid = 0;
    bus.rel_slot = 0;
    repeat (3) @(negedge clk);
    chk("rst_sdram_rd", 32'(bus.sdram_rd), 0);
    chk("rst_sdram_refresh", 32'(bus.sdram_refresh), 0);
    chk("rst_sdram_addr", 32'(bus.sdram_addr), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    chk("rst_req_err", 32'(bus.req_err), 0);
    chk("rst_slot_valid", 32'(bus.slot_valid), 0);
    chk("rst_fill_slot", 32'(bus.fill_slot), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    rst = 0;
    @(negedge clk);
    start_req(3, 23'h100);
    wait_slot(0);
    chk("fill_after_1", 32'(bus.fill_slot), 1);
    for (int x = 0; x < IW; x++) rd(0, x, x == 5 ? 16'h9E9F : pixv(23'h100, 3, x));
    start_req(0, 23'h7FFFFC);
    wait_slot(1);
    rd(1, 0, 16'h5859);
    rd(1, 2, 16'hA4A5);
    rd(1, 7, pixv(23'h7FFFFC, 0, 7));
    start_req(1, 23'h400);
    wait_slot(2);
    start_req(2, 23'h400);
    wait_slot(3);
    @(negedge clk);
    chk("full_fill_slot", 32'(bus.fill_slot), 0);
    chk("full_slot_valid", 32'(bus.slot_valid), 32'hF);
    chk("full_req_ready", 32'(bus.req_ready), 0);
    rd(2, 4, pixv(23'h400, 1, 4));
    rd(3, 6, pixv(23'h400, 2, 6));
    release_slot(1);
    chk("rel1_slot_valid", 32'(bus.slot_valid), 32'hD);
    chk("rel1_req_ready", 32'(bus.req_ready), 0);
    release_slot(0);
    chk("rel0_slot_valid", 32'(bus.slot_valid), 32'hC);
    chk("rel0_req_ready", 32'(bus.req_ready), 1);
    start_req(IH, 23'h100);
    chk("err_pulse", 32'(bus.req_err), 1);
    @(negedge clk);
    chk("err_pulse_end", 32'(bus.req_err), 0);
    chk("err_fill_slot", 32'(bus.fill_slot), 0);
    chk("err_req_ready", 32'(bus.req_ready), 1);
    repeat (5) @(negedge clk);
    start = rd_cnt;
    start_req(5, 23'h200);
    t = 0;
    while (rd_cnt < start + 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    addr_q.delete();
    chk("mid_rst_sdram_rd", 32'(bus.sdram_rd), 0);
    chk("mid_rst_sdram_addr", 32'(bus.sdram_addr), 0);
    chk("mid_rst_rd_data", 32'(bus.rd_data), 0);
    chk("mid_rst_slot_valid", 32'(bus.slot_valid), 0);
    chk("mid_rst_fill_slot", 32'(bus.fill_slot), 0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 1);
    stray = 1;
    repeat (2) @(negedge clk);
    stray = 0;
    repeat (2) @(negedge clk);
    chk("stray_slot_valid", 32'(bus.slot_valid), 0);
    start_req(5, 23'h200);
    wait_slot(0);
    chk("refill_fill_slot", 32'(bus.fill_slot), 1);
    for (int x = 0; x < IW; x++) rd(0, x, pixv(23'h200, 5, x));
    repeat (3) @(negedge clk);
    chk("addr_q_drained", 32'(addr_q.size()), 0);
`ifdef LINE_PREFETCH_REFRESH_EN
    chk("refresh_seen", 32'(ref_cnt > 0), 1);
`else
    chk("refresh_absent", 32'(ref_cnt), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
